// File: rtl/haraka_pkg.sv
// Shared Haraka definitions: FSM encoding, round counts, AES round primitives,
// round-constant generation and the Haraka-512 truncation ranges.
package haraka_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

    localparam int unsigned NUM_ROUNDS    = 5;
    localparam int unsigned AES_PER_ROUND = 2;

    // Haraka-512 digest: bytes 8-15, 24-31, 32-39, 48-55 (byte 0 at [511:504])
    localparam int unsigned TR0_HI = 447, TR0_LO = 384;
    localparam int unsigned TR1_HI = 319, TR1_LO = 256;
    localparam int unsigned TR2_HI = 255, TR2_LO = 192;
    localparam int unsigned TR3_HI = 127, TR3_LO = 64;

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_FLAT[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One aesenc round: ShiftRows, SubBytes, MixColumns, AddRoundKey.
    function automatic logic [127:0] aes_round(input logic [127:0] blk, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   a0, a1, a2, a3, t;
        logic [127:0] res;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                s[4*c+r] = sbox(blk[127 - 8*(4*((c+r)%4)+r) -: 8]);
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[4*c];
            a1 = s[4*c+1];
            a2 = s[4*c+2];
            a3 = s[4*c+3];
            t  = a0 ^ a1 ^ a2 ^ a3;
            res[127 - 32*c      -: 8] = a0 ^ t ^ xtime(a0 ^ a1);
            res[127 - 32*c - 8  -: 8] = a1 ^ t ^ xtime(a1 ^ a2);
            res[127 - 32*c - 16 -: 8] = a2 ^ t ^ xtime(a2 ^ a3);
            res[127 - 32*c - 24 -: 8] = a3 ^ t ^ xtime(a3 ^ a0);
        end
        return res ^ key;
    endfunction

    // Constant k, byte j = ((16k + j) * 157) mod 256 XOR 0x36.
    function automatic logic [127:0] rc_block(input logic [5:0] k);
        logic [127:0] rc;
        for (int unsigned j = 0; j < 16; j++)
            rc[127 - 8*j -: 8] = 8'((32'(k) * 16 + j) * 157) ^ 8'h36;
        return rc;
    endfunction

    function automatic logic [5:0] rc_index(input logic wide, input logic [3:0] rnd,
                                            input logic [1:0] aes, input logic [1:0] lane);
        int unsigned lanes;
        lanes = wide ? 32'd4 : 32'd2;
        return 6'(32'(rnd) * lanes * AES_PER_ROUND + 32'(aes) * lanes + 32'(lane));
    endfunction

    function automatic logic [127:0] unpack_lo(input logic [127:0] x, input logic [127:0] y);
        return {x[127:96], y[127:96], x[95:64], y[95:64]};
    endfunction

    function automatic logic [127:0] unpack_hi(input logic [127:0] x, input logic [127:0] y);
        return {x[63:32], y[63:32], x[31:0], y[31:0]};
    endfunction

    function automatic logic [255:0] digest_of(input logic wide, input logic [511:0] s);
        return wide ? {s[TR0_HI:TR0_LO], s[TR1_HI:TR1_LO], s[TR2_HI:TR2_LO], s[TR3_HI:TR3_LO]}
                    : s[511:256];
    endfunction

endpackage

// File: rtl/haraka_ctrl_if.sv
// Job request / digest handshake bundle between a requester and haraka_ctrl.
interface haraka_ctrl_if;
    logic         start;
    logic         ready;
    logic         mode;
    logic [511:0] msg_in;
    logic [255:0] digest;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    modport master (output start, mode, msg_in, out_ready,
                    input  ready, digest, out_valid, busy);
    modport slave  (input  start, mode, msg_in, out_ready,
                    output ready, digest, out_valid, busy);
endinterface

// File: rtl/haraka_core.sv
// One Haraka AES step: four parallel aesenc rounds with per-lane round constants.
module haraka_core
    import haraka_pkg::*;
(
    input  logic [255:0] block_top_1,
    input  logic [255:0] block_top_2,
    input  logic [3:0]   round,
    input  logic [1:0]   round_aes,
    input  logic         hara_c,
    output logic [511:0] block_out
);
    logic [511:0] blocks;

    assign blocks = {block_top_1, block_top_2};

    always_comb begin
        block_out = '0;
        for (int unsigned b = 0; b < 4; b++)
            block_out[511 - 128*b -: 128] =
                aes_round(blocks[511 - 128*b -: 128], rc_block(rc_index(hara_c, round, round_aes, 2'(b))));
    end
endmodule

// File: rtl/haraka_leaf.sv
// Haraka leaf permutations (mix256, mix512) and the feed-forward XOR.
module mix256
    import haraka_pkg::*;
(
    input  logic [255:0] din,
    output logic [255:0] dout
);
    assign dout = {unpack_lo(din[255:128], din[127:0]), unpack_hi(din[255:128], din[127:0])};
endmodule

module mix512
    import haraka_pkg::*;
(
    input  logic [511:0] din,
    output logic [511:0] dout
);
    logic [127:0] t, u, v, w;

    assign t    = unpack_lo(din[511:384], din[383:256]);
    assign u    = unpack_hi(din[511:384], din[383:256]);
    assign v    = unpack_lo(din[255:128], din[127:0]);
    assign w    = unpack_hi(din[255:128], din[127:0]);
    assign dout = {unpack_hi(u, w), unpack_lo(v, t), unpack_hi(v, t), unpack_lo(u, w)};
endmodule

module f_forward_512 (
    input  logic         mode,
    input  logic [511:0] state,
    input  logic [511:0] msg,
    output logic [511:0] dout
);
    assign dout = {state[511:256] ^ msg[511:256],
                   mode ? (state[255:0] ^ msg[255:0]) : state[255:0]};
endmodule

// File: rtl/haraka_ctrl.sv
// Iterative Haraka-256/512 controller: one AES step per cycle, mix after every
// second step, feed-forward in FINAL, digest held in DONE until taken.
module haraka_ctrl
    import haraka_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET_N,
    haraka_ctrl_if.slave  io
);
    state_t       fsm;
    logic [511:0] state_q, msg_q;
    logic         mode_q;
    logic [2:0]   rnd;
    logic         aes;
    logic         ready_q, busy_q, out_valid_q;
    logic [255:0] digest_q;

    logic [255:0] core_lo, mix256_out;
    logic [511:0] core_out, mix512_out, fed, run_next, accept_val;

    assign core_lo = mode_q ? state_q[255:0] : '0;

    haraka_core u_core (
        .block_top_1 (state_q[511:256]),
        .block_top_2 (core_lo),
        .round       ({1'b0, rnd}),
        .round_aes   ({1'b0, aes}),
        .hara_c      (mode_q),
        .block_out   (core_out)
    );

    mix256 u_mix256 (.din(core_out[511:256]), .dout(mix256_out));
    mix512 u_mix512 (.din(core_out), .dout(mix512_out));
    f_forward_512 u_ff (.mode(mode_q), .state(state_q), .msg(msg_q), .dout(fed));

    // Haraka-256 keeps the lower half of state and msg copy at zero throughout.
    always_comb begin
        run_next = mode_q ? core_out : {core_out[511:256], 256'h0};
        if (aes)
            run_next = mode_q ? mix512_out : {mix256_out, 256'h0};
    end

    assign accept_val = io.mode ? io.msg_in : {io.msg_in[511:256], 256'h0};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fsm         <= IDLE;
            state_q     <= '0;
            msg_q       <= '0;
            mode_q      <= 1'b0;
            rnd         <= '0;
            aes         <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            digest_q    <= '0;
        end else begin
            case (fsm)
                IDLE: if (io.start && ready_q) begin
                    state_q <= accept_val;
                    msg_q   <= accept_val;
                    mode_q  <= io.mode;
                    rnd     <= '0;
                    aes     <= 1'b0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                    fsm     <= RUN;
                end
                RUN: begin
                    state_q <= run_next;
                    aes     <= ~aes;
                    if (aes == 1'(AES_PER_ROUND - 1)) begin
                        if (rnd == 3'(NUM_ROUNDS - 1))
                            fsm <= FINAL;
                        else
                            rnd <= rnd + 3'd1;
                    end
                end
                FINAL: begin
                    state_q     <= fed;
                    digest_q    <= digest_of(mode_q, fed);
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    fsm         <= DONE;
                end
                DONE: if (io.out_ready) begin
                    out_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    fsm         <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign io.ready     = ready_q;
    assign io.busy      = busy_q;
    assign io.out_valid = out_valid_q;
    assign io.digest    = digest_q;
endmodule

// File: tb/tb_haraka_ctrl.sv
// Directed bench for haraka_ctrl with an independent software Haraka model.
module tb_haraka_ctrl;
    logic CLK = 1'b0;
    logic RESET_N = 1'b1;

    haraka_ctrl_if io ();

    haraka_ctrl dut (.CLK(CLK), .RESET_N(RESET_N), .io(io));

    always #5 CLK = ~CLK;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned cyc        = 0;
    logic [7:0]  sb [256];

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] m_aes(input logic [127:0] blk, input logic [127:0] key);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = blk[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                b[4*c+rr] = sb[a[4*((c+rr)%4)+rr]];
        for (int c = 0; c < 4; c++) begin
            r[127 - 32*c      -: 8] = gmul(8'h02, b[4*c])   ^ gmul(8'h03, b[4*c+1]) ^ b[4*c+2] ^ b[4*c+3];
            r[127 - 32*c - 8  -: 8] = b[4*c] ^ gmul(8'h02, b[4*c+1]) ^ gmul(8'h03, b[4*c+2]) ^ b[4*c+3];
            r[127 - 32*c - 16 -: 8] = b[4*c] ^ b[4*c+1] ^ gmul(8'h02, b[4*c+2]) ^ gmul(8'h03, b[4*c+3]);
            r[127 - 32*c - 24 -: 8] = gmul(8'h03, b[4*c]) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(8'h02, b[4*c+3]);
        end
        return r ^ key;
    endfunction

    function automatic logic [127:0] m_rc(input int k);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[127 - 8*j -: 8] = 8'(((k*16 + j) * 157) % 256) ^ 8'h36;
        return r;
    endfunction

    function automatic logic [127:0] m_lo(input logic [127:0] x, input logic [127:0] y);
        return {x[127:96], y[127:96], x[95:64], y[95:64]};
    endfunction

    function automatic logic [127:0] m_hi(input logic [127:0] x, input logic [127:0] y);
        return {x[63:32], y[63:32], x[31:0], y[31:0]};
    endfunction

    function automatic logic [255:0] m_haraka(input logic wide, input logic [511:0] msg);
        logic [127:0] s [4];
        logic [127:0] tmp, t2;
        int lanes;
        lanes = wide ? 4 : 2;
        for (int b = 0; b < 4; b++) s[b] = msg[511 - 128*b -: 128];
        for (int r = 0; r < 5; r++) begin
            for (int a = 0; a < 2; a++)
                for (int b = 0; b < lanes; b++)
                    s[b] = m_aes(s[b], m_rc(r*2*lanes + a*lanes + b));
            if (wide) begin
                tmp  = m_lo(s[0], s[1]);
                s[0] = m_hi(s[0], s[1]);
                s[1] = m_lo(s[2], s[3]);
                s[2] = m_hi(s[2], s[3]);
                s[3] = m_lo(s[0], s[2]);
                s[0] = m_hi(s[0], s[2]);
                s[2] = m_hi(s[1], tmp);
                s[1] = m_lo(s[1], tmp);
            end else begin
                tmp  = m_lo(s[0], s[1]);
                t2   = m_hi(s[0], s[1]);
                s[0] = tmp;
                s[1] = t2;
            end
        end
        for (int b = 0; b < lanes; b++) s[b] ^= msg[511 - 128*b -: 128];
        return wide ? {s[0][63:0], s[1][63:0], s[2][127:64], s[3][127:64]} : {s[0], s[1]};
    endfunction

    function automatic logic [511:0] pat(input logic [7:0] base);
        logic [511:0] v;
        for (int j = 0; j < 64; j++) v[511 - 8*j -: 8] = base + 8'(j);
        return v;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic launch(input string tag, input logic m, input logic [511:0] msg);
        check({tag, "_ready_idle"}, 256'(io.ready), 256'(1));
        io.mode   = m;
        io.msg_in = msg;
        io.start  = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        io.start  = 1'b0;
        io.mode   = ~m;
        io.msg_in = ~msg;
        check({tag, "_busy_run"},  256'(io.busy),  256'(1));
        check({tag, "_ready_run"}, 256'(io.ready), 256'(0));
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (io.out_valid !== 1'b1 && n < 40) begin
            @(posedge CLK);
            @(negedge CLK);
            n++;
        end
        if (io.out_valid !== 1'b1) check({tag, "_valid_timeout"}, 256'(io.out_valid), 256'(1));
    endtask

    logic [511:0] msg_a, msg_b, msg_c, msg_e;
    logic [255:0] exp_a, exp_b, exp_c, held;
    int           n, w;
    int unsigned  acc [4];

    initial begin
        io.start     = 1'b0;
        io.mode      = 1'b0;
        io.msg_in    = '0;
        io.out_ready = 1'b1;
        #1 RESET_N = 1'b0;
        build_sbox();
        msg_a = pat(8'h00);
        msg_b = pat(8'h00);
        msg_c = pat(8'h80);
        exp_a = m_haraka(1'b0, msg_a);
        exp_b = m_haraka(1'b1, msg_b);
        exp_c = m_haraka(1'b1, msg_c);
        repeat (2) @(negedge CLK);
        check("rst_ready",     256'(io.ready),     256'(1));
        check("rst_out_valid", 256'(io.out_valid), 256'(0));
        check("rst_busy",      256'(io.busy),      256'(0));
        check("rst_digest",    io.digest,          256'(0));
        RESET_N = 1'b1;
        @(negedge CLK);

        // Haraka-256, lower half of msg_in must be ignored
        launch("a", 1'b0, msg_a);
        wait_valid("a", n);
        check("a_latency", 256'(n), 256'(11));
        check("a_digest", io.digest, exp_a);
        @(posedge CLK);
        @(negedge CLK);
        check("a_ready_after", 256'(io.ready),     256'(1));
        check("a_valid_after", 256'(io.out_valid), 256'(0));

        // Haraka-512 with round/aes sequence into the core
        launch("b", 1'b1, msg_b);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("b_round_seq%0d", k), 256'({dut.u_core.round, dut.u_core.round_aes}),
                  256'({4'(k/2), 2'(k%2)}));
            @(posedge CLK);
            @(negedge CLK);
        end
        wait_valid("b", n);
        check("b_latency_tail", 256'(n), 256'(1));
        check("b_digest", io.digest, exp_b);
        @(posedge CLK);
        @(negedge CLK);

        // Backpressure with ignored start pulses, then simultaneous start/out_ready
        io.out_ready = 1'b0;
        launch("c", 1'b1, msg_c);
        wait_valid("c", n);
        check("c_digest", io.digest, exp_c);
        for (int i = 0; i < 20; i++) begin
            io.start = 1'(i % 2);
            @(posedge CLK);
            @(negedge CLK);
            check("c_hold_digest", io.digest, exp_c);
            check("c_hold_ready",  256'(io.ready),     256'(0));
            check("c_hold_valid",  256'(io.out_valid), 256'(1));
        end
        io.start     = 1'b1;
        io.out_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        io.start = 1'b0;
        check("c_xfer_ready", 256'(io.ready),     256'(1));
        check("c_xfer_busy",  256'(io.busy),      256'(0));
        check("c_xfer_valid", 256'(io.out_valid), 256'(0));
        @(posedge CLK);
        @(negedge CLK);
        check("c_no_new_job", 256'(io.busy), 256'(0));

        // Reset in the middle of RUN aborts; the next job runs cleanly
        launch("d", 1'b1, msg_c);
        repeat (4) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        #2 RESET_N = 1'b0;
        #1;
        check("d_rst_ready",  256'(io.ready),     256'(1));
        check("d_rst_busy",   256'(io.busy),      256'(0));
        check("d_rst_valid",  256'(io.out_valid), 256'(0));
        check("d_rst_digest", io.digest,          256'(0));
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        launch("d2", 1'b0, msg_a);
        wait_valid("d2", n);
        check("d2_latency", 256'(n), 256'(11));
        check("d2_digest", io.digest, exp_a);

        // Back-to-back, start held high, modes alternating
        io.start = 1'b1;
        for (int j = 0; j < 4; j++) begin
            msg_e     = pat(8'(17 + 64*j));
            io.mode   = 1'(j % 2);
            io.msg_in = msg_e;
            w = 0;
            while (io.ready !== 1'b1 && w < 40) begin
                @(posedge CLK);
                @(negedge CLK);
                w++;
            end
            if (io.ready !== 1'b1) check("e_ready_timeout", 256'(io.ready), 256'(1));
            @(posedge CLK);
            @(negedge CLK);
            acc[j]    = cyc;
            io.mode   = ~io.mode;
            io.msg_in = ~msg_e;
            wait_valid("e", n);
            held = m_haraka(1'(j % 2), msg_e);
            check($sformatf("e_digest%0d", j), io.digest, held);
            if (j > 0) check($sformatf("e_interval%0d", j), 256'(acc[j] - acc[j-1]), 256'(13));
        end
        io.start = 1'b0;
        @(posedge CLK);
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
